// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment BCD display block.
// Segment patterns are active-low, bit order 6543210 (g f e d c b a).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } disp_state_t;

  // 10**n, used to size the overflow threshold at elaboration time.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// One BCD nibble to an active-low seven-segment pattern.
// A blank request or a non-decimal nibble both produce an unlit digit.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode the nibble; anything that is not 0-9 stays dark rather than X.
  always_comb begin
    // NOTE: assigning a default before the case guarantees every path drives seg,
    // so no latch can be inferred.
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0: seg = SEG_TABLE[0];
        4'd1: seg = SEG_TABLE[1];
        4'd2: seg = SEG_TABLE[2];
        4'd3: seg = SEG_TABLE[3];
        4'd4: seg = SEG_TABLE[4];
        4'd5: seg = SEG_TABLE[5];
        4'd6: seg = SEG_TABLE[6];
        4'd7: seg = SEG_TABLE[7];
        4'd8: seg = SEG_TABLE[8];
        4'd9: seg = SEG_TABLE[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// Multi-digit score/level readout: sequential double-dabble binary-to-BCD
// conversion (one shift per clock), registered active-low segment patterns,
// leading-zero blanking, overflow dashes and whole-display blinking.
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_WIDTH  = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [BIN_WIDTH-1:0]        value,
  input  logic                        load,
  input  logic                        blank_zeros,
  input  logic                        blink_en,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [NUM_DIGITS-1:0][6:0]  leds
);

  localparam int BCD_W   = NUM_DIGITS * 4;
  localparam int CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam longint unsigned  OVF_LIMIT  = pow10(NUM_DIGITS);
  localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  disp_state_t state, state_next;

  logic [BCD_W-1:0]     bcd, bcd_next;
  logic [BIN_WIDTH-1:0] bin, bin_next;
  logic [CNT_W-1:0]     shift_cnt;
  logic                 ovf_pend;
  logic                 ovf_now;
  logic                 last_shift;

  logic [NUM_DIGITS-1:0][6:0] pattern;
  logic [NUM_DIGITS-1:0][6:0] dec_seg;
  logic [NUM_DIGITS:0]        lead_zero;
  logic [NUM_DIGITS-1:0]      blank_dig;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  assign ovf_now    = (64'(value) >= OVF_LIMIT);
  assign last_shift = (shift_cnt == LAST_SHIFT);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic: load only accepted in IDLE, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load)       state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    bcd_next = '0;
    carry    = bin[BIN_WIDTH-1];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = bcd[i*4 +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_next[i*4 +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
    bin_next = {bin[BIN_WIDTH-2:0], 1'b0};
  end

  // Conversion datapath: capture on load, shift once per SHIFT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      ovf_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin       <= value;
          bcd       <= '0;
          shift_cnt <= '0;
          ovf_pend  <= ovf_now;
        end
        SHIFT: begin
          bin       <= bin_next;
          bcd       <= bcd_next;
          shift_cnt <= shift_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero detection on the final BCD result; digit 0 is never blanked.
  always_comb begin
    lead_zero             = '0;
    lead_zero[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (bcd_next[i*4 +: 4] == 4'd0);
    end
    blank_dig = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank_dig[i] = blank_zeros && lead_zero[i];
    end
  end

  // Per-digit decoders fed from the value the last shift will produce.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_digit_dec u_dec (
      .bcd   (bcd_next[g*4 +: 4]),
      .blank (blank_dig[g]),
      .seg   (dec_seg[g])
    );
  end

  // Display register: updated on the edge that enters DONE, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern  <= {NUM_DIGITS{SEG_BLANK}};
      overflow <= 1'b0;
    end else if (state == SHIFT && last_shift) begin
      overflow <= ovf_pend;
      pattern  <= ovf_pend ? {NUM_DIGITS{SEG_DASH}} : dec_seg;
    end
  end

  // Blink timer: idle at count 0 / phase ON while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Blink masking on the registered pattern.
  always_comb begin
    leds = blink_off ? {NUM_DIGITS{SEG_BLANK}} : pattern;
  end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed bench for seg7_bcd_display (6 digits, 20-bit value, blink every 4 clocks).
module tb_seg7_bcd_display;

  localparam int ND = 6;
  localparam int BW = 20;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_DASH  = {6{7'b0111111}};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [BW-1:0]     value;
  logic              load;
  logic              blank_zeros;
  logic              blink_en;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ND-1:0][6:0] leds;

  int checks   = 0;
  int failures = 0;

  seg7_bcd_display #(
    .NUM_DIGITS (ND),
    .BIN_WIDTH  (BW),
    .BLINK_DIV  (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value       (value),
    .load        (load),
    .blank_zeros (blank_zeros),
    .blink_en    (blink_en),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  // Reference display image built from decimal arithmetic and a hand-written table.
  function automatic logic [41:0] exp_leds(input int unsigned v, input bit bz);
    logic [6:0]  tbl [10];
    int unsigned d [6];
    int unsigned div;
    int          msd;
    logic [41:0] r;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    div = 1;
    msd = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = (v / div) % 10;
      if (d[i] != 0) msd = i;
      div = div * 10;
    end
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*7 +: 7] = (bz && i > msd) ? 7'h7F : tbl[d[i]];
    end
    return r;
  endfunction

  task automatic start_load(input int unsigned v, input bit bz);
    @(negedge clk);
    value       = BW'(v);
    blank_zeros = bz;
    load        = 1'b1;
    @(negedge clk);
    load        = 1'b0;
  endtask

  // Called one negedge after the load edge; expects 20 busy cycles then a done pulse.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 20) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d want=20", name, n);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s done_pulse got=%b want=1", name, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width got=%b want=0", name, done);
    end
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    load        = 1'b1;
    value       = '0;
    blank_zeros = 1'b0;
    blink_en    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== ALL_BLANK) begin
      failures++;
      $display("FAIL reset_leds got=%h want=%h", leds, ALL_BLANK);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b want=000", busy, done, overflow);
    end
    reset_n = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done("reset_zero");
    checks++;
    if (leds !== exp_leds(0, 1'b0)) begin
      failures++;
      $display("FAIL reset_zero_leds got=%h want=%h", leds, exp_leds(0, 1'b0));
    end
  endtask

  task automatic test_convert;
    int unsigned vals [5] = '{123456, 42, 0, 1000000, 999999};
    bit          bzs  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit          ovfs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [41:0] want;
    for (int i = 0; i < 5; i++) begin
      start_load(vals[i], bzs[i]);
      wait_done($sformatf("conv_%0d", vals[i]));
      want = ovfs[i] ? ALL_DASH : exp_leds(vals[i], bzs[i]);
      checks++;
      if (leds !== want) begin
        failures++;
        $display("FAIL conv_%0d_leds got=%h want=%h", vals[i], leds, want);
      end
      checks++;
      if (overflow !== ovfs[i]) begin
        failures++;
        $display("FAIL conv_%0d_overflow got=%b want=%b", vals[i], overflow, ovfs[i]);
      end
    end
  endtask

  task automatic test_blank_hold;
    start_load(42, 1'b1);
    wait_done("hold_42");
    blank_zeros = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== exp_leds(42, 1'b1)) begin
      failures++;
      $display("FAIL blank_hold got=%h want=%h", leds, exp_leds(42, 1'b1));
    end
  endtask

  task automatic test_back_to_back;
    int n_done;
    start_load(654321, 1'b0);
    repeat (4) @(negedge clk);
    value = BW'(111111);
    load  = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d want=1", n_done);
    end
    checks++;
    if (leds !== exp_leds(654321, 1'b0)) begin
      failures++;
      $display("FAIL b2b_leds got=%h want=%h", leds, exp_leds(654321, 1'b0));
    end
  endtask

  task automatic test_reset_abort;
    int n_done;
    start_load(777, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (leds !== ALL_BLANK) begin
      failures++;
      $display("FAIL abort_leds got=%h want=%h", leds, ALL_BLANK);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags got=%b%b want=00", busy, done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_done  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d want=0", n_done);
    end
  endtask

  task automatic test_blink;
    logic [41:0] pat;
    logic [41:0] want;
    pat = exp_leds(42, 1'b1);
    start_load(42, 1'b1);
    wait_done("blink_42");
    blink_en = 1'b1;
    for (int j = 0; j < 14; j++) begin
      if (j > 0) @(negedge clk);
      want = (((j / 4) % 2) == 0) ? pat : ALL_BLANK;
      checks++;
      if (leds !== want) begin
        failures++;
        $display("FAIL blink_step_%0d got=%h want=%h", j, leds, want);
      end
    end
    blink_en = 1'b0;
    @(negedge clk);
    checks++;
    if (leds !== pat) begin
      failures++;
      $display("FAIL blink_restore got=%h want=%h", leds, pat);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blank_hold();
    test_back_to_back();
    test_reset_abort();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
